// File: rtl/alu_issue_unit.sv
// Command FIFO feeding an external combinational ALU through a three-state
// issue FSM. Results are captured, then held until the consumer handshakes.
module alu_issue_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_IN1,
  input  logic [WIDTH-1:0] CMD_IN2,
  input  logic [3:0]       CMD_SEL,
  input  logic [1:0]       CMD_TAG,
  output logic [WIDTH-1:0] ALU_IN1,
  output logic [WIDTH-1:0] ALU_IN2,
  output logic [3:0]       SEL_ALU,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [1:0]       RES_TAG,
  output logic [7:0]       OP_COUNT,
  output logic             BUSY
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       sel;
    logic [1:0]       tag;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             push, pop;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       tag_q, tag_d, res_tag_q, res_tag_d;
  logic [7:0]       op_count_q, op_count_d;

  assign head = mem_q[rd_ptr_q];

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{in1: CMD_IN1, in2: CMD_IN2, sel: CMD_SEL, tag: CMD_TAG};
    end
  end

  always_comb begin
    push        = CMD_VALID && cmd_ready_q;
    pop         = 1'b0;
    state_d     = state_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    sel_d       = sel_q;
    tag_d       = tag_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        res_data_d = ALU_OUT;
        res_tag_d  = tag_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (RES_READY) begin
          op_count_d = op_count_q + 8'd1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      alu_in1_d = head.in1;
      alu_in2_d = head.in2;
      sel_d     = head.sel;
      tag_d     = head.tag;
    end

    // Pop only ever sees registered occupancy, so a fresh push is never bypassed.
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    cmd_ready_d = (count_d != CW'(DEPTH));
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
    res_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      sel_q       <= '0;
      tag_q       <= '0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      sel_q       <= sel_d;
      tag_q       <= tag_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      op_count_q  <= op_count_d;
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign BUSY      = busy_q;
  assign RES_VALID = res_valid_q;
  assign ALU_IN1   = alu_in1_q;
  assign ALU_IN2   = alu_in2_q;
  assign SEL_ALU   = sel_q;
  assign RES_DATA  = res_data_q;
  assign RES_TAG   = res_tag_q;
  assign OP_COUNT  = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: reference ALU attached, a negedge monitor logs
// accepted commands (as expected results) and delivered results for comparison.
module tb_alu_issue_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [31:0] CMD_IN1 = '0, CMD_IN2 = '0;
  logic [3:0]  CMD_SEL = '0;
  logic [1:0]  CMD_TAG = '0;
  logic [31:0] ALU_IN1, ALU_IN2, ALU_OUT, RES_DATA;
  logic [3:0]  SEL_ALU;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [1:0]  RES_TAG;
  logic [7:0]  OP_COUNT;
  logic        BUSY;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  t;
  } res_t;

  res_t       exp_q[$];
  res_t       obs_q[$];
  logic [7:0] exp_ops = '0;
  int         passed = 0;
  int         total = 0;

  always #5 CLK = ~CLK;

  alu_issue_unit #(.DEPTH(4), .WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_IN1(CMD_IN1), .CMD_IN2(CMD_IN2), .CMD_SEL(CMD_SEL), .CMD_TAG(CMD_TAG),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .SEL_ALU(SEL_ALU), .ALU_OUT(ALU_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_TAG(RES_TAG), .OP_COUNT(OP_COUNT), .BUSY(BUSY)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign ALU_OUT = ref_alu(ALU_IN1, ALU_IN2, SEL_ALU);

  // Inputs only change just after posedge, so negedge values are what the next edge sees.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      obs_q.delete();
      exp_ops = '0;
    end else begin
      if (CMD_VALID && CMD_READY) exp_q.push_back('{d: ref_alu(CMD_IN1, CMD_IN2, CMD_SEL), t: CMD_TAG});
      if (RES_VALID && RES_READY) begin
        obs_q.push_back('{d: RES_DATA, t: RES_TAG});
        exp_ops = exp_ops + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                     input logic [1:0] t);
    CMD_VALID = 1'b1; CMD_IN1 = a; CMD_IN2 = b; CMD_SEL = s; CMD_TAG = t;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic drain(output bit ok);
    CMD_VALID = 1'b0;
    RES_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!BUSY && !RES_VALID) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CMD_VALID = 1'b1; RES_READY = 1'b1;
    tick(); tick();
    CMD_VALID = 1'b0;
    total++;
    if ({CMD_READY, RES_VALID, BUSY} !== 3'b100) $display("FAIL reset_flags: got %b expected 100", {CMD_READY, RES_VALID, BUSY});
    else passed++;
    total++;
    if ({RES_DATA, RES_TAG, OP_COUNT} !== 42'd0) $display("FAIL reset_result: got %h expected 0", {RES_DATA, RES_TAG, OP_COUNT});
    else passed++;
    total++;
    if ({ALU_IN1, ALU_IN2, SEL_ALU} !== 68'd0) $display("FAIL reset_alu_regs: got %h expected 0", {ALU_IN1, ALU_IN2, SEL_ALU});
    else passed++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    RES_READY = 1'b1;
    put(32'd1, 32'd1, 4'b0000, 2'd1);
    total++;
    if (RES_VALID !== 1'b0) $display("FAIL single_k0_valid: got %b expected 0", RES_VALID);
    else passed++;
    tick();
    total++;
    if ({RES_VALID, ALU_IN1, ALU_IN2, SEL_ALU} !== {1'b0, 32'd1, 32'd1, 4'b0000})
      $display("FAIL single_drive: got %h expected %h", {RES_VALID, ALU_IN1, ALU_IN2, SEL_ALU}, {1'b0, 32'd1, 32'd1, 4'b0000});
    else passed++;
    tick();
    total++;
    if ({RES_VALID, RES_DATA, RES_TAG} !== {1'b1, 32'd2, 2'd1})
      $display("FAIL single_result: got %h expected %h", {RES_VALID, RES_DATA, RES_TAG}, {1'b1, 32'd2, 2'd1});
    else passed++;
    tick();
    total++;
    if ({OP_COUNT, RES_VALID, BUSY} !== {8'd1, 1'b0, 1'b0})
      $display("FAIL single_done: got %h expected %h", {OP_COUNT, RES_VALID, BUSY}, {8'd1, 1'b0, 1'b0});
    else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_burst();
    logic [31:0] want_d[5];
    logic [1:0]  want_t[5];
    bit ok;
    want_d = '{32'd5, 32'd0, 32'd1, 32'd1, 32'd8};
    want_t = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    RES_READY = 1'b0;
    put(32'd2, 32'd3, 4'b0000, 2'd2);
    put(32'd1, 32'd1, 4'b1000, 2'd0);
    put(32'd1, 32'd1, 4'b0110, 2'd1);
    put(32'h0F, 32'd1, 4'b0111, 2'd2);
    put(32'd5, 32'd3, 4'b0000, 2'd3);
    total++;
    if (CMD_READY !== 1'b0) $display("FAIL burst_full_ready: got %b expected 0", CMD_READY);
    else passed++;
    put(32'd9, 32'd9, 4'b0000, 2'd0);
    total++;
    if (CMD_READY !== 1'b0) $display("FAIL burst_refused: got %b expected 0", CMD_READY);
    else passed++;
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 5) $display("FAIL burst_count: got %0d results (drained %0d) expected 5", obs_q.size(), ok);
    else passed++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {want_d[i], want_t[i]})
        $display("FAIL burst_result[%0d]: got %h expected %h", i, obs_q[i], {want_d[i], want_t[i]});
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, e_d;
    logic [7:0]  ops0;
    bit ok;
    a = $urandom; b = $urandom;
    e_d = a - b;
    ops0 = exp_ops;
    RES_READY = 1'b0;
    put(a, b, 4'b1000, 2'd3);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({RES_VALID, BUSY, RES_DATA, RES_TAG, OP_COUNT} !== {1'b1, 1'b1, e_d, 2'd3, ops0})
        $display("FAIL backpressure_hold[%0d]: got %h expected %h", i,
                 {RES_VALID, BUSY, RES_DATA, RES_TAG, OP_COUNT}, {1'b1, 1'b1, e_d, 2'd3, ops0});
      else passed++;
      tick();
    end
    drain(ok);
    total++;
    if (!ok || OP_COUNT !== ops0 + 8'd1) $display("FAIL backpressure_release: got %0d expected %0d", OP_COUNT, ops0 + 8'd1);
    else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_wrap();
    logic [3:0] sels[4];
    int pushed;
    bit ok;
    sels = '{4'b0000, 4'b1000, 4'b0110, 4'b0111};
    pushed = 0;
    RST = 1'b1; tick(); RST = 1'b0;
    for (int cyc = 0; cyc < 6000 && pushed < 257; cyc++) begin
      CMD_VALID = ($urandom_range(3) != 0);
      CMD_IN1 = $urandom; CMD_IN2 = $urandom;
      CMD_SEL = sels[$urandom_range(3)];
      CMD_TAG = 2'($urandom);
      RES_READY = ($urandom_range(3) != 0);
      if (CMD_VALID && CMD_READY) pushed++;
      tick();
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 257 || exp_q.size() != 257)
      $display("FAIL wrap_count: got %0d results expected 257 (model %0d, drained %0d)", obs_q.size(), exp_q.size(), ok);
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (OP_COUNT !== 8'd1) $display("FAIL wrap_opcount: got %0d expected 1", OP_COUNT);
    else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit seen;
    RES_READY = 1'b0;
    put(32'd10, 32'd4, 4'b1000, 2'd0);
    put(32'd1, 32'd2, 4'b0000, 2'd1);
    put(32'd3, 32'd5, 4'b0110, 2'd2);
    put(32'd7, 32'd6, 4'b0111, 2'd3);
    RES_READY = 1'b1;
    tick();
    total++;
    if (obs_q.size() != 1 || exp_q.size() == 0 || obs_q[0] !== {32'd6, 2'd0})
      $display("FAIL rstmid_first: got %0d results expected first result 6 tag 0", obs_q.size());
    else passed++;
    total++;
    if ({RES_VALID, BUSY, CMD_READY} !== 3'b011) $display("FAIL rstmid_in_drive: got %b expected 011", {RES_VALID, BUSY, CMD_READY});
    else passed++;
    RST = 1'b1; CMD_VALID = 1'b1;
    tick();
    RST = 1'b0; CMD_VALID = 1'b0;
    total++;
    if ({RES_VALID, CMD_READY, BUSY, OP_COUNT} !== {3'b010, 8'd0})
      $display("FAIL rstmid_after: got %h expected %h", {RES_VALID, CMD_READY, BUSY, OP_COUNT}, {3'b010, 8'd0});
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (RES_VALID || BUSY) seen = 1'b1;
      tick();
    end
    total++;
    if (seen || obs_q.size() != 0) $display("FAIL rstmid_stale: got activity %b results %0d expected none", seen, obs_q.size());
    else passed++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    RES_READY = 1'b0;
    put(32'd1, 32'd1, 4'b0000, 2'd0);
    for (int i = 0; i < 4; i++) put($urandom, $urandom, 4'b0110, 2'(i));
    total++;
    if (CMD_READY !== 1'b0) $display("FAIL sim_full: got %b expected 0", CMD_READY);
    else passed++;
    CMD_VALID = 1'b1; CMD_IN1 = 32'hDEAD; CMD_IN2 = 32'd1; CMD_SEL = 4'b0000; CMD_TAG = 2'd3;
    RES_READY = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    total++;
    if ({CMD_READY, RES_VALID} !== 2'b10) $display("FAIL sim_full_pop: got %b expected 10", {CMD_READY, RES_VALID});
    else passed++;
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 5 || obs_q !== exp_q) $display("FAIL sim_full_results: got %0d results expected 5 in order", obs_q.size());
    else passed++;
    exp_q.delete(); obs_q.delete();
    RES_READY = 1'b0;
    put(32'd8, 32'd2, 4'b1000, 2'd1);
    put(32'd4, 32'd4, 4'b0000, 2'd2);
    tick();
    CMD_VALID = 1'b1; CMD_IN1 = 32'hF0; CMD_IN2 = 32'h3C; CMD_SEL = 4'b0111; CMD_TAG = 2'd3;
    RES_READY = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    total++;
    if ({RES_VALID, BUSY, CMD_READY} !== 3'b011) $display("FAIL sim_push_pop: got %b expected 011", {RES_VALID, BUSY, CMD_READY});
    else passed++;
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 3 || obs_q[2] !== {32'h30, 2'd3} || obs_q !== exp_q)
      $display("FAIL sim_push_results: got %0d results expected 3 ending 30/3", obs_q.size());
    else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_random_wrap();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
